// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// widths, and the funct3 legality rule.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 >= 3'd3);
    end else begin
      bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane formatter: store byte enables and lane-aligned data,
// sign/zero-extended load value, and the misalignment flag for an access.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] raw_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wword_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  // Replicating the narrow store data across lanes lets the enables pick it.
  always_comb begin
    be_o    = '0;
    wword_o = '0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
      end
      default: begin
        be_o    = '0;
        wword_o = '0;
      end
    endcase
  end

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_o = {24'd0, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_o = {16'd0, half_sel};
      F3_W:    rdata_o = raw_i;
      default: rdata_o = '0;
    endcase
  end

  always_comb begin
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      2'd1:    misalign_o = addr_lo_i[0];
      2'd2:    misalign_o = (addr_lo_i != 2'd0);
      default: misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with LATENCY (1..15) cycles
// to response. Define DMEM_PERF_EN to add load/store/error response counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_errs
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          f3_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic                range_err;
  logic                acc_err;
  logic                busy_done;
  logic                commit;
  logic [IDX_W-1:0]    word_idx;
  logic [DATA_W-1:0]   raw_word;
  logic [BE_W-1:0]     lane_be;
  logic [DATA_W-1:0]   lane_wword;
  logic [DATA_W-1:0]   lane_load;
  logic                lane_misalign;
  logic [DATA_W-1:0]   rdata_d;
  logic                err_d;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // All access decoding works from the captured request, so req_* may change freely once accepted.
  always_comb begin
    range_err = ({2'b00, addr_q[ADDR_W-1:2]} >= 32'(DEPTH_WORDS));
    word_idx  = addr_q[IDX_W+1:2];
    raw_word  = range_err ? '0 : mem[word_idx];
    acc_err   = range_err || lane_misalign || f3_illegal(we_q, f3_q);
    busy_done = (state_q == ST_BUSY) && (cnt_q == '0);
    commit    = busy_done && we_q && !acc_err;
    err_d     = acc_err;
    rdata_d   = (acc_err || we_q) ? '0 : lane_load;
  end

  dmem_lane_fmt u_lane_fmt (
    .funct3_i   (f3_q),
    .addr_lo_i  (addr_q[1:0]),
    .raw_i      (raw_word),
    .wdata_i    (wdata_q),
    .be_o       (lane_be),
    .wword_o    (lane_wword),
    .rdata_o    (lane_load),
    .misalign_o (lane_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            f3_q        <= req_funct3;
            cnt_q       <= CNT_W'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately unreset; a reset during BUSY clears state_q first, so no commit happens.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (lane_be[b]) begin
          mem[word_idx][8*b +: 8] <= lane_wword[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_PERF_EN
  logic resp_fire;
  logic [31:0] perf_loads_q, perf_stores_q, perf_errs_q;

  assign resp_fire   = resp_valid_q && resp_ready;
  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_errs   = perf_errs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_errs_q   <= '0;
    end else if (resp_fire) begin
      if (resp_err_q) begin
        perf_errs_q <= perf_errs_q + 32'd1;
      end else if (we_q) begin
        perf_stores_q <= perf_stores_q + 32'd1;
      end else begin
        perf_loads_q <= perf_loads_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-level memory model.
// Checks perf counters too when DMEM_PERF_EN is defined.
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int LAT     = 2;
  localparam int PREFILL = 16;

  logic        clk;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [2:0]  reqFunct3;
  logic        respValid;
  logic        respReady;
  logic [31:0] respRdata;
  logic        respErr;
`ifdef DMEM_PERF_EN
  logic [31:0] perfLoads, perfStores, perfErrs;
`endif

  int errors = 0;
  int checks = 0;
  int lastAcceptWait = 0;
  int expLoads = 0;
  int expStores = 0;
  int expErrs = 0;

  logic [7:0] modelMem [0:4*DEPTH-1];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_we     (reqWe),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .req_funct3 (reqFunct3),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_rdata (respRdata),
    .resp_err   (respErr)
`ifdef DMEM_PERF_EN
    ,
    .perf_loads  (perfLoads),
    .perf_stores (perfStores),
    .perf_errs   (perfErrs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: size from funct3, errors from alignment/range/legality, little-endian bytes.
  function automatic void modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [2:0] f3, output logic [31:0] expData, output logic expErr);
    int size;
    logic illegal;
    logic [31:0] mask;
    size    = 1 << f3[1:0];
    illegal = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
    expErr  = illegal || ((addr % size) != 0) || ((addr >> 2) >= DEPTH);
    expData = '0;
    if (!expErr) begin
      for (int i = 0; i < size; i++) begin
        if (we) modelMem[addr + i] = wdata[8*i +: 8];
        else    expData[8*i +: 8] = modelMem[addr + i];
      end
      if (we) begin
        expData = '0;
      end else if (size < 4 && f3[2] == 1'b0) begin
        mask = (32'd1 << (8*size)) - 32'd1;
        if (expData[8*size-1]) expData = expData | ~mask;
      end
    end
  endfunction

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input int holdCycles, input string tag);
    logic [31:0] expData;
    logic        expErr;
    int          waitCyc;
    int          lat;
    modelAccess(we, addr, wdata, f3, expData, expErr);
    @(negedge clk);
    reqValid  = 1'b1;
    reqWe     = we;
    reqAddr   = addr;
    reqWdata  = wdata;
    reqFunct3 = f3;
    waitCyc = 0;
    while (!reqReady && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    if (waitCyc >= 20) checkOutput({tag, "_accept_timeout"}, {31'd0, reqReady}, 32'd1);
    lastAcceptWait = waitCyc;
    @(posedge clk);
    #1;
    reqWe     = $urandom_range(0, 1);
    reqAddr   = $urandom;
    reqWdata  = $urandom;
    reqFunct3 = 3'($urandom_range(0, 7));
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (respValid) begin
        lat = c;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
    checkOutput({tag, "_rdata"}, respRdata, expData);
    checkOutput({tag, "_err"}, {31'd0, respErr}, {31'd0, expErr});
    checkOutput({tag, "_ready_in_resp"}, {31'd0, reqReady}, 32'd0);
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_flags"}, {29'd0, respValid, respErr, reqReady}, {29'd0, 1'b1, expErr, 1'b0});
      checkOutput({tag, "_hold_rdata"}, respRdata, expData);
    end
    respReady = 1'b1;
    @(posedge clk);
    #1;
    respReady = 1'b0;
    reqValid  = 1'b0;
    checkOutput({tag, "_after_hs"}, {30'd0, respValid, reqReady}, {30'd0, 1'b0, 1'b1});
    if (expErr) expErrs++;
    else if (we) expStores++;
    else expLoads++;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, {31'd0, reqReady}, 32'd1);
    checkOutput({tag, "_resp_valid"}, {31'd0, respValid}, 32'd0);
    checkOutput({tag, "_resp_rdata"}, respRdata, 32'd0);
    checkOutput({tag, "_resp_err"}, {31'd0, respErr}, 32'd0);
`ifdef DMEM_PERF_EN
    checkOutput({tag, "_perf_loads"}, perfLoads, 32'd0);
    checkOutput({tag, "_perf_stores"}, perfStores, 32'd0);
    checkOutput({tag, "_perf_errs"}, perfErrs, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    logic        w;
    logic [2:0]  legalLoad [5];
    legalLoad = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst_n = 1'b0;
    reqValid = 1'b0;
    reqWe = 1'b0;
    reqAddr = '0;
    reqWdata = '0;
    reqFunct3 = '0;
    respReady = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    for (int i = 0; i < PREFILL; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 3'd2, 0, "prefill");

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, "sw_10");
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd2, 0, "lw_10");
    applyStimulus(1'b0, 32'h13, 32'h0, 3'd0, 0, "lb_13");
    applyStimulus(1'b0, 32'h13, 32'h0, 3'd4, 0, "lbu_13");
    applyStimulus(1'b0, 32'h12, 32'h0, 3'd1, 0, "lh_12");
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd5, 0, "lhu_10");
    applyStimulus(1'b1, 32'h11, 32'hAAAAAA55, 3'd0, 0, "sb_11");
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd2, 0, "lw_10_after_sb");
    applyStimulus(1'b0, 32'h12, 32'h0, 3'd2, 0, "lw_misaligned");
    applyStimulus(1'b1, 32'h11, 32'h00001234, 3'd1, 0, "sh_misaligned");
    applyStimulus(1'b0, 32'(4 * DEPTH), 32'h0, 3'd2, 0, "lw_out_of_range");
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd3, 0, "load_f3_3");
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd2, 5, "lw_hold5");
    applyStimulus(1'b0, 32'h14, 32'h0, 3'd2, 0, "lw_back_to_back");
    checkOutput("accept_after_hs", 32'(lastAcceptWait), 32'd0);

    // Abandon a store mid-BUSY with an async reset; the old word must survive.
    applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 3'd2, 0, "sw_20_old");
    @(negedge clk);
    reqValid  = 1'b1;
    reqWe     = 1'b1;
    reqAddr   = 32'h20;
    reqWdata  = 32'h12345678;
    reqFunct3 = 3'd2;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    rst_n = 1'b0;
    #2;
    checkResetValues("midreset");
    repeat (2) @(negedge clk);
    checkResetValues("midreset_held");
    rst_n = 1'b1;
    expLoads = 0;
    expStores = 0;
    expErrs = 0;
    applyStimulus(1'b0, 32'h20, 32'h0, 3'd2, 0, "lw_20_after_reset");

    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = 32'((DEPTH + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3));
      else a = 32'($urandom_range(0, PREFILL - 1) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) f = 3'($urandom_range(0, 7));
      else if (w) f = 3'($urandom_range(0, 2));
      else f = legalLoad[$urandom_range(0, 4)];
      if (f[1:0] == 2'd1 && $urandom_range(0, 1) == 1) a[0] = 1'b0;
      if (f[1:0] == 2'd2 && $urandom_range(0, 1) == 1) a[1:0] = 2'd0;
      applyStimulus(w, a, $urandom, f, $urandom_range(0, 2), "random");
    end

`ifdef DMEM_PERF_EN
    checkOutput("perf_loads", perfLoads, 32'(expLoads));
    checkOutput("perf_stores", perfStores, 32'(expStores));
    checkOutput("perf_errs", perfErrs, 32'(expErrs));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RISC-V core. Serves load/store requests from the core's load-store path (the initiator) over a valid/ready request channel and a valid/ready response channel.
- Handles RV32I access sizes (B/H/W, signed/unsigned loads), byte-lane writes, misalignment and range errors.
- Has a programmable access latency, so the pipeline can be exercised against non-zero memory delay.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored; the word index is req_addr[31:2].
- LATENCY, 2: cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the value is taken from the low bytes
- req_funct3  in  3  RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access was misaligned, out of range, or had an illegal funct3

Behaviour:
- Reset values (asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- Memory array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/funct3, compute err, load counter=LATENCY-1, go to BUSY.
  - BUSY: req_ready=0. Decrement the counter each cycle. When counter==0, the edge leaving BUSY:
    - commits a store if err==0 (byte enables from funct3 and addr[1:0]);
    - registers resp_rdata/resp_err;
    - moves to RESP.
  - RESP: resp_valid=1; outputs held stable until resp_valid&&resp_ready, then go to IDLE.
- Latency:
  - resp_valid rises exactly LATENCY cycles after the accepting edge.
  - One outstanding request at most. req_ready never asserts in the same cycle as resp_valid.
- A new request can be accepted in the cycle after the response handshake.
- Load extraction:
  - Byte or half is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- Store lanes:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
- Error conditions (err=1; no write; rdata=0):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
  - Load funct3 in {3,6,7}.
  - Store funct3 >= 3.
- Read-after-write: a load accepted after a store's response handshake sees the stored data.
- Reset asserted mid-operation (BUSY or RESP): the transaction is abandoned, and a store not yet committed is never written.
- Inputs are sampled only at acceptance; req_* changes during BUSY/RESP are ignored.

Optional Feature:
- Macro DMEM_PERF_EN.
- Defined:
  - Adds output ports perf_loads[31:0], perf_stores[31:0] and perf_errs[31:0].
  - Each counter increments once per response handshake of the matching kind: error responses count only in perf_errs, never in loads or stores.
  - Counters wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state encoding (ST_IDLE, ST_BUSY, ST_RESP);
  - the width localparams.
- Sub-module dmem_lane_fmt (combinational) takes funct3, addr[1:0], a raw word and wdata. It produces:
  - byte enables[3:0];
  - the lane-aligned store word;
  - the extended load value;
  - the misalign flag.
- The top holds the FSM, counter, array and error logic.

Test Plan:
- LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> each resp_valid arrives exactly 2 cycles after acceptance; load rdata=0xDEADBEEF, err=0.
- After that word is stored:
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x12 -> 0xFFFFDEAD
  - LHU 0x10 -> 0x0000BEEF
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF.
- Error responses (err=1, rdata=0, memory unchanged):
  - LW 0x12;
  - SH 0x11;
  - LW at byte address 4*DEPTH_WORDS;
  - load funct3=3.
- Hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stay stable and req_ready stays 0; handshake on cycle 6, new request accepted on cycle 7.
- Reset (rst_n=0) during BUSY of SW 0x20 data 0x12345678, where the word previously held 0xCAFEF00D -> after release all outputs are at reset values and LW 0x20 returns 0xCAFEF00D.
- With DMEM_PERF_EN, sequence 2 loads, 1 store, 1 misaligned load -> perf_loads=2, perf_stores=1, perf_errs=1.
